// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
//   Bundles the controller-side capture/commit signals and the consumer-side
//   valid/ready drain port of the ALU result FIFO, together with its status.
//
//   Modports:
//     master : the environment (ALU controller, datapath, consumer) driving
//              exec_en/rvalid/alu_result/alu_flags/out_ready/clear_err and
//              observing the FIFO head and status.
//     slave  : the FIFO itself.
//
//   Signals:
//     exec_en     EXECUTE cycle, capture ALU outputs
//     rvalid      MEM_WRITE cycle, commit the pending capture
//     alu_result  ALU datapath result          (DATA_W)
//     alu_flags   ALU status flags             (FLAG_W)
//     out_valid   head entry available
//     out_ready   consumer accepts head entry
//     out_data    head entry result            (DATA_W)
//     out_flags   head entry flags             (FLAG_W)
//     count       entries held, 0..DEPTH       ($clog2(DEPTH)+1)
//     full        count == DEPTH
//     empty       count == 0
//     overflow    sticky: a commit was dropped because the FIFO was full
//     seq_err     sticky: rvalid seen with no pending capture
//     clear_err   clears overflow and seq_err
// ---------------------------------------------------------------------------
interface alu_result_fifo_if #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 4,
   parameter int DEPTH  = 4
);
   logic                       exec_en;
   logic                       rvalid;
   logic [DATA_W-1:0]          alu_result;
   logic [FLAG_W-1:0]          alu_flags;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          out_data;
   logic [FLAG_W-1:0]          out_flags;
   logic [$clog2(DEPTH):0]     count;
   logic                       full;
   logic                       empty;
   logic                       overflow;
   logic                       seq_err;
   logic                       clear_err;

   modport master (
      output exec_en, rvalid, alu_result, alu_flags, out_ready, clear_err,
      input  out_valid, out_data, out_flags, count, full, empty, overflow, seq_err
   );

   modport slave (
      input  exec_en, rvalid, alu_result, alu_flags, out_ready, clear_err,
      output out_valid, out_data, out_flags, count, full, empty, overflow, seq_err
   );
endinterface

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Downstream stage of the ALU controller. The ALU result and flags are
//   captured on the EXECUTE cycle and committed into a small show-ahead FIFO
//   on the MEM_WRITE cycle. Entries drain over a valid/ready port. Dropped
//   commits and commits without a capture raise sticky status flags.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous, active-low reset
//     bus      alu_result_fifo_if.slave (capture/commit inputs, drain port,
//              count/full/empty and sticky overflow/seq_err status)
// ---------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 4,
   parameter int DEPTH  = 4
) (
   input logic              clk,
   input logic              reset_n,
   alu_result_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_W + FLAG_W;

   logic [DATA_W-1:0] cap_data_q,  cap_data_d;
   logic [FLAG_W-1:0] cap_flags_q, cap_flags_d;
   logic              cap_valid_q, cap_valid_d;
   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [ENT_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              seq_err_q, seq_err_d;

   logic              is_empty;
   logic              is_full;
   logic              pop;
   logic              commit_req;
   logic              push;
   logic              drop;
   logic [ENT_W-1:0]  head;

   // Full/empty come from the occupancy counter so that equal pointers are
   // never ambiguous.
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(DEPTH));
   assign head     = mem_q[rd_ptr_q];

   // A pop while full frees a slot in the same edge, so a simultaneous commit
   // is still accepted; only a commit into a full FIFO without a pop drops.
   always_comb begin
      pop        = !is_empty && bus.out_ready;
      commit_req = bus.rvalid && cap_valid_q;
      push       = commit_req && (!is_full || pop);
      drop       = commit_req && !push;
   end

   always_comb begin
      cap_data_d  = cap_data_q;
      cap_flags_d = cap_flags_q;
      cap_valid_d = cap_valid_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_d  = overflow_q;
      seq_err_d   = seq_err_q;

      // The commit always consumes the old capture; a new exec_en in the
      // same cycle reloads the capture and keeps it pending.
      if (bus.rvalid) begin
         cap_valid_d = 1'b0;
      end
      if (bus.exec_en) begin
         cap_data_d  = bus.alu_result;
         cap_flags_d = bus.alu_flags;
         cap_valid_d = 1'b1;
      end

      if (push) begin
         mem_d[wr_ptr_q] = {cap_flags_q, cap_data_q};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      // Set events take priority over clear_err.
      if (bus.clear_err) begin
         overflow_d = 1'b0;
         seq_err_d  = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
      if (bus.rvalid && !cap_valid_q) begin
         seq_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_data_q  <= '0;
         cap_flags_q <= '0;
         cap_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         cap_data_q  <= cap_data_d;
         cap_flags_q <= cap_flags_d;
         cap_valid_q <= cap_valid_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         seq_err_q   <= seq_err_d;
      end
   end

   // Head outputs read zero whenever nothing is held, so stale slots never
   // show through.
   assign bus.out_valid = !is_empty;
   assign bus.out_data  = is_empty ? '0 : head[DATA_W-1:0];
   assign bus.out_flags = is_empty ? '0 : head[ENT_W-1:DATA_W];
   assign bus.count     = count_q;
   assign bus.full      = is_full;
   assign bus.empty     = is_empty;
   assign bus.overflow  = overflow_q;
   assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Directed bench for alu_result_fifo. Expected entries go into a scoreboard
//   queue as commits are issued; a separate monitor pops and compares each
//   time the DUT hands an entry to the consumer.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;
   logic clk;
   logic reset_n;
   int   testsRun;
   int   failures;
   logic [11:0] expQ [$];

   alu_result_fifo_if #(.DATA_W(8), .FLAG_W(4), .DEPTH(4)) bus ();

   alu_result_fifo #(.DATA_W(8), .FLAG_W(4), .DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, then returns just after the next rising edge.
   task automatic applyStimulus(input logic ex, input logic rv,
                                input logic [7:0] res, input logic [3:0] fl,
                                input logic rdy, input logic clr);
      bus.exec_en    = ex;
      bus.rvalid     = rv;
      bus.alu_result = res;
      bus.alu_flags  = fl;
      bus.out_ready  = rdy;
      bus.clear_err  = clr;
      @(posedge clk);
      #1;
   endtask

   // Monitor: a handshake seen on the falling edge is the entry that leaves
   // on the next rising edge.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL unexpected_pop: got data %0h, expected no entry", bus.out_data);
         end else begin
            logic [11:0] e;
            e = expQ.pop_front();
            checkOutput("pop_data",  32'(bus.out_data),  32'(e[7:0]));
            checkOutput("pop_flags", 32'(bus.out_flags), 32'(e[11:8]));
         end
      end
   end

   initial begin
      logic [7:0] v;
      testsRun = 0;
      failures = 0;
      bus.exec_en = 0; bus.rvalid = 0; bus.alu_result = 0; bus.alu_flags = 0;
      bus.out_ready = 0; bus.clear_err = 0;

      // Reset values after release.
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_out_data",  32'(bus.out_data),  0);
      checkOutput("rst_out_flags", 32'(bus.out_flags), 0);
      checkOutput("rst_count",     32'(bus.count),     0);
      checkOutput("rst_full",      32'(bus.full),      0);
      checkOutput("rst_empty",     32'(bus.empty),     1);
      checkOutput("rst_overflow",  32'(bus.overflow),  0);
      checkOutput("rst_seq_err",   32'(bus.seq_err),   0);

      // Asynchronous reset with two entries held.
      applyStimulus(1, 0, 8'h31, 4'h1, 0, 0);
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      applyStimulus(1, 0, 8'h32, 4'h2, 0, 0);
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      applyStimulus(0, 0, 8'h00, 4'h0, 0, 0);
      checkOutput("pre_rst_count", 32'(bus.count), 2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_count",     32'(bus.count),     0);
      checkOutput("async_rst_out_valid", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      checkOutput("post_rst_empty", 32'(bus.empty), 1);

      // Single operation with one-cycle latency to the head.
      applyStimulus(1, 0, 8'h5A, 4'b0001, 0, 0);
      expQ.push_back({4'b0001, 8'h5A});
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      checkOutput("single_out_valid", 32'(bus.out_valid), 1);
      checkOutput("single_out_data",  32'(bus.out_data),  32'h5A);
      checkOutput("single_out_flags", 32'(bus.out_flags), 32'h1);
      checkOutput("single_count",     32'(bus.count),     1);
      applyStimulus(0, 0, 8'h00, 4'h0, 1, 0);
      checkOutput("single_empty", 32'(bus.empty), 1);

      // Fill to full, fifth commit overflows, then drain through the wrap.
      for (int i = 1; i <= 5; i++) begin
         v = i[7:0];
         applyStimulus(1, 0, v, v[3:0], 0, 0);
         if (i <= 4) expQ.push_back({v[3:0], v});
         applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
         if (i == 4) begin
            checkOutput("fill_full",     32'(bus.full),     1);
            checkOutput("fill_count",    32'(bus.count),    4);
            checkOutput("fill_overflow", 32'(bus.overflow), 0);
         end
      end
      checkOutput("ovf_flag",  32'(bus.overflow), 1);
      checkOutput("ovf_count", 32'(bus.count),    4);
      checkOutput("ovf_head",  32'(bus.out_data), 32'h01);
      repeat (4) applyStimulus(0, 0, 8'h00, 4'h0, 1, 0);
      checkOutput("drain_empty",  32'(bus.empty),  1);
      checkOutput("drain_sb",     32'(expQ.size()), 0);
      checkOutput("ovf_sticky",   32'(bus.overflow), 1);
      applyStimulus(0, 0, 8'h00, 4'h0, 0, 1);
      checkOutput("ovf_cleared",  32'(bus.overflow), 0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 4; i++) begin
         v = 8'h10 + i[7:0];
         applyStimulus(1, 0, v, v[3:0], 0, 0);
         expQ.push_back({v[3:0], v});
         applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      end
      applyStimulus(1, 0, 8'h14, 4'h4, 0, 0);
      expQ.push_back({4'h4, 8'h14});
      applyStimulus(0, 1, 8'h00, 4'h0, 1, 0);
      checkOutput("pp_count",    32'(bus.count),    4);
      checkOutput("pp_full",     32'(bus.full),     1);
      checkOutput("pp_overflow", 32'(bus.overflow), 0);
      repeat (4) applyStimulus(0, 0, 8'h00, 4'h0, 1, 0);
      checkOutput("pp_empty", 32'(bus.empty),   1);
      checkOutput("pp_sb",    32'(expQ.size()), 0);

      // Sequencing errors and sticky clear priority.
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      checkOutput("seq_set",   32'(bus.seq_err), 1);
      checkOutput("seq_count", 32'(bus.count),   0);
      applyStimulus(0, 0, 8'h00, 4'h0, 0, 1);
      checkOutput("seq_clear", 32'(bus.seq_err), 0);
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 1);
      checkOutput("seq_set_wins", 32'(bus.seq_err), 1);
      applyStimulus(0, 0, 8'h00, 4'h0, 0, 1);
      checkOutput("seq_clear2", 32'(bus.seq_err), 0);

      // Overwrite of an uncommitted capture, then exec and commit together.
      applyStimulus(1, 0, 8'hAA, 4'hA, 0, 0);
      applyStimulus(1, 0, 8'hBB, 4'hB, 0, 0);
      expQ.push_back({4'hB, 8'hBB});
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      checkOutput("ovr_count", 32'(bus.count),    1);
      checkOutput("ovr_head",  32'(bus.out_data), 32'hBB);
      applyStimulus(1, 0, 8'hC1, 4'h3, 0, 0);
      expQ.push_back({4'h3, 8'hC1});
      applyStimulus(1, 1, 8'hC2, 4'h5, 0, 0);
      checkOutput("same_cycle_count",   32'(bus.count),   2);
      checkOutput("same_cycle_seq_err", 32'(bus.seq_err), 0);
      expQ.push_back({4'h5, 8'hC2});
      applyStimulus(0, 1, 8'h00, 4'h0, 0, 0);
      checkOutput("reload_count", 32'(bus.count), 3);
      repeat (3) applyStimulus(0, 0, 8'h00, 4'h0, 1, 0);
      applyStimulus(0, 0, 8'h00, 4'h0, 0, 0);
      checkOutput("final_empty", 32'(bus.empty),   1);
      checkOutput("final_sb",    32'(expQ.size()), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end
endmodule
